// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler
// Game-flow controller for an obstacle-scrolling game. Sequences IDLE/RUN/
// PAUSE/OVER, generates the scroll-step pulse from a reloadable prescaler,
// counts passed obstacles (speeding the scroll up every SPEEDUP_EVERY passes)
// and refills the two obstacle banks from a free-running 32-bit LFSR.
//
// Ports
//   clk          sole clock, all state changes on posedge
//   reset        asynchronous, active-high reset
//   start        pulse: IDLE->RUN, OVER->IDLE
//   pause        pulse: RUN<->PAUSE
//   collide      level: player hit an obstacle (RUN/PAUSE -> OVER)
//   genRandom1   level: bank 1 refill request (acted on at its rising edge)
//   genRandom2   level: bank 0 refill request (acted on at its rising edge)
//   isPassed     level: obstacle pair passed (counted at its rising edge)
//   cont         one-cycle scroll-step pulse
//   inp1, inp0   obstacle banks, [1] = word A, [0] = word B
//   score        saturating pass count
//   running      high in RUN only
//   game_over    high in OVER only
module obstacle_scheduler #(
    parameter int unsigned TICK_INIT     = 25_000_000,
    parameter int unsigned TICK_MIN      = 2_500_000,
    parameter int unsigned TICK_STEP     = 1_250_000,
    parameter int unsigned SPEEDUP_EVERY = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             collide,
    input  logic             genRandom1,
    input  logic             genRandom2,
    input  logic             isPassed,
    output logic             cont,
    output logic [1:0][23:0] inp1,
    output logic [1:0][23:0] inp0,
    output logic [15:0]      score,
    output logic             running,
    output logic             game_over
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [31:0] TICK_INIT_W    = 32'(TICK_INIT);
    localparam logic [31:0] TICK_MIN_W     = 32'(TICK_MIN);
    localparam logic [31:0] TICK_STEP_W    = 32'(TICK_STEP);
    localparam logic [31:0] SPEEDUP_LAST_W = 32'(SPEEDUP_EVERY - 1);
    localparam logic [31:0] LFSR_SEED      = 32'hACE1_2024;
    // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;

    state_t           state_q, state_d;
    logic [31:0]      prescaler_q, prescaler_d;
    logic [31:0]      period_q, period_d;
    logic [31:0]      pass_cnt_q, pass_cnt_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [15:0]      score_q, score_d;
    logic [1:0][23:0] inp1_q, inp1_d;
    logic [1:0][23:0] inp0_q, inp0_d;
    logic             cont_q, cont_d;
    logic             running_q, running_d;
    logic             game_over_q, game_over_d;
    logic             gen1_prev_q, gen2_prev_q, passed_prev_q;
    logic             gen1_rise_s, gen2_rise_s, passed_rise_s;
    logic [1:0][23:0] refill_s;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        lfsr_step = {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

    // An all-zero low field would mean an empty obstacle slot; force it to 1.
    function automatic logic [23:0] make_word(input logic [15:0] half);
        if (half[4:0] == 5'd0) begin
            make_word = {8'h00, half[15:5], 5'd1};
        end else begin
            make_word = {8'h00, half};
        end
    endfunction

    // max(p - TICK_STEP, TICK_MIN) evaluated in 33 bits so nothing wraps.
    function automatic logic [31:0] faster(input logic [31:0] p);
        if ({1'b0, p} >= ({1'b0, TICK_MIN_W} + {1'b0, TICK_STEP_W})) begin
            faster = p - TICK_STEP_W;
        end else begin
            faster = TICK_MIN_W;
        end
    endfunction

    assign gen1_rise_s   = genRandom1 & ~gen1_prev_q;
    assign gen2_rise_s   = genRandom2 & ~gen2_prev_q;
    assign passed_rise_s = isPassed & ~passed_prev_q;
    assign refill_s      = {make_word(lfsr_q[31:16]), make_word(lfsr_q[15:0])};

    // Next-state, prescaler, scoring and refill logic.
    always_comb begin
        state_d     = state_q;
        prescaler_d = prescaler_q;
        period_d    = period_q;
        pass_cnt_d  = pass_cnt_q;
        score_d     = score_q;
        cont_d      = 1'b0;
        lfsr_d      = lfsr_step(lfsr_q);

        // Refills are honoured in every state, including IDLE.
        if (gen1_rise_s) begin
            inp1_d = refill_s;
        end else begin
            inp1_d = inp1_q;
        end
        if (gen2_rise_s) begin
            inp0_d = refill_s;
        end else begin
            inp0_d = inp0_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    period_d    = TICK_INIT_W;
                    prescaler_d = TICK_INIT_W;
                    score_d     = 16'd0;
                    pass_cnt_d  = 32'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // A speed-up only changes period; the running count keeps going
                // and any reload in this same cycle still uses the old period.
                if (passed_rise_s) begin
                    if (score_q != 16'hFFFF) begin
                        score_d = score_q + 16'd1;
                    end else begin
                        score_d = score_q;
                    end
                    if (pass_cnt_q >= SPEEDUP_LAST_W) begin
                        pass_cnt_d = 32'd0;
                        period_d   = faster(period_q);
                    end else begin
                        pass_cnt_d = pass_cnt_q + 32'd1;
                    end
                end else begin
                    score_d = score_q;
                end
                // collide beats pause beats tick; a suppressed tick leaves the
                // count frozen so it fires on the first RUN clock afterwards.
                if (collide) begin
                    state_d = S_OVER;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else if (prescaler_q <= 32'd1) begin
                    cont_d      = 1'b1;
                    prescaler_d = period_q;
                end else begin
                    prescaler_d = prescaler_q - 32'd1;
                end
            end
            S_PAUSE: begin
                if (collide) begin
                    state_d = S_OVER;
                end else if (pause) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_PAUSE;
                end
            end
            S_OVER: begin
                if (start) begin
                    state_d = S_IDLE;
                    score_d = 16'd0;
                end else begin
                    state_d = S_OVER;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        running_d   = (state_d == S_RUN);
        game_over_d = (state_d == S_OVER);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            prescaler_q   <= TICK_INIT_W;
            period_q      <= TICK_INIT_W;
            pass_cnt_q    <= 32'd0;
            lfsr_q        <= LFSR_SEED;
            score_q       <= 16'd0;
            inp1_q        <= '0;
            inp0_q        <= '0;
            cont_q        <= 1'b0;
            running_q     <= 1'b0;
            game_over_q   <= 1'b0;
            gen1_prev_q   <= 1'b0;
            gen2_prev_q   <= 1'b0;
            passed_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            prescaler_q   <= prescaler_d;
            period_q      <= period_d;
            pass_cnt_q    <= pass_cnt_d;
            lfsr_q        <= lfsr_d;
            score_q       <= score_d;
            inp1_q        <= inp1_d;
            inp0_q        <= inp0_d;
            cont_q        <= cont_d;
            running_q     <= running_d;
            game_over_q   <= game_over_d;
            gen1_prev_q   <= genRandom1;
            gen2_prev_q   <= genRandom2;
            passed_prev_q <= isPassed;
        end
    end

    assign cont      = cont_q;
    assign inp1      = inp1_q;
    assign inp0      = inp0_q;
    assign score     = score_q;
    assign running   = running_q;
    assign game_over = game_over_q;

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 Parameter TICK_INIT, default 25_000_000, initial clocks between scroll steps.
REQ-002 Parameter TICK_MIN, default 2_500_000, floor for the scroll period.
REQ-003 Parameter TICK_STEP, default 1_250_000, period decrement per speed-up.
REQ-004 Parameter SPEEDUP_EVERY, default 8, passes per speed-up.
REQ-005 Timing is decided: one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  sole clock; all state changes on posedge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  one-cycle pulse: IDLE->RUN, or OVER->IDLE.
REQ-009 pause  input  1  one-cycle pulse: toggles RUN<->PAUSE.
REQ-010 collide  input  1  level: player hit an obstacle.
REQ-011 genRandom1  input  1  level from obstacle motion: bank 1 refill request.
REQ-012 genRandom2  input  1  level from obstacle motion: bank 0 refill request.
REQ-013 isPassed  input  1  level from obstacle motion: obstacle pair passed.
REQ-014 cont  output  1  one-cycle scroll-step pulse to obstacle motion.
REQ-015 inp1  output  [1:0][23:0]  obstacle bank 1, registered.
REQ-016 inp0  output  [1:0][23:0]  obstacle bank 0, registered.
REQ-017 score  output  16  pass count, saturating.
REQ-018 running  output  1  high in RUN only.
REQ-019 game_over  output  1  high in OVER only.

Function
REQ-020 FSM states: IDLE, RUN, PAUSE, OVER; all outputs registered.
REQ-021 IDLE: start -> RUN; prescaler loaded with current period; score=0; period=TICK_INIT.
REQ-022 RUN: prescaler decrements each clock; on reaching 1, cont=1 for exactly one cycle and prescaler reloads with current period.
REQ-023 First cont comes exactly `period` clocks after the RUN entry edge; subsequent cont pulses are spaced `period` clocks apart.
REQ-024 RUN: pause -> PAUSE; PAUSE: pause -> RUN; in PAUSE the prescaler is frozen, with no cont, and it resumes from the frozen count.
REQ-025 collide high in RUN or PAUSE -> OVER next edge.
REQ-026 OVER: cont=0, score held, banks held; start -> IDLE.
REQ-027 Same-cycle priority: collide > pause > tick; a tick coinciding with collide or pause yields no cont.
REQ-028 start is ignored in RUN/PAUSE; pause is ignored in IDLE/OVER.
REQ-029 LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, seed 32'hACE1_2024, advances every clock in every state.
REQ-030 Word A = {8'h00, lfsr[31:16]}; word B = {8'h00, lfsr[15:0]}; in each word, bits [4:0] == 0 are replaced by 5'd1.
REQ-031 Rising edge of genRandom1 (edge regs reset to 0) -> next edge inp1[1]=A, inp1[0]=B from the current LFSR value.
REQ-032 Rising edge of genRandom2 -> next edge inp0[1]=A, inp0[0]=B.
REQ-033 Both edges in the same cycle -> both banks load identical words from the same LFSR value.
REQ-034 A held-high request loads once only; refill is accepted in every state, including IDLE, because obstacle motion raises both requests in its init state.
REQ-035 Rising edge of isPassed in RUN -> score+1, saturating at 16'hFFFF; isPassed edges in other states are ignored.
REQ-036 Every SPEEDUP_EVERY-th accepted pass sets period = max(period-TICK_STEP, TICK_MIN), with no underflow; the new period takes effect at the next reload, and the current count is not altered.
REQ-037 Period and prescaler are 32-bit unsigned.

Reset
REQ-038 Reset values: state=IDLE, cont=0, score=0, running=0, game_over=0, period=TICK_INIT, prescaler=TICK_INIT, lfsr=seed, inp1=inp0=0, all edge-detect regs=0.
REQ-039 Reset asserted mid-RUN forces all reset values asynchronously, with no cont glitch; after release the block waits in IDLE for start.

Verification (TICK_INIT=10, TICK_MIN=4, TICK_STEP=2, SPEEDUP_EVERY=2)
REQ-040 Release reset, start pulse -> running=1 next edge; cont pulses at 10, 20, 30 clocks after entry, each 1 cycle wide.
REQ-041 In RUN, give 4 isPassed rising edges -> score=4; the period, applied at the next reload, becomes 8 then 6; 6 more passes -> period floors at 4, never 2.
REQ-042 Pause 3 clocks after a cont, hold 50 clocks, pause again -> the next cont comes 7 clocks after resume; no cont during PAUSE.
REQ-043 collide in the same cycle as a due tick -> no cont, game_over=1 next edge; start -> IDLE with score=0; start again -> RUN with period 10.
REQ-044 genRandom1 and genRandom2 both high at reset release -> both banks load once from the seed-derived words, with every [4:0] field nonzero; holding the requests high causes no further load.
REQ-045 Drive score to 16'hFFFF and add one more pass -> score stays 16'hFFFF; assert reset -> all outputs match REQ-038 immediately.
